xnor_reduce_sched: RTL

//   Round-robin scheduler that shares a single SLICE-bit XNOR-reduce datapath between

---
 rtl/xnor_reduce_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/xnor_reduce_sched.sv
// Round-robin scheduler sharing one SLICE-bit serial XNOR-reduce unit among NREQ requesters.
// Optional per-request XOR/XNOR select is compiled in with `define XNOR_REDUCE_SCHED_MODE_EN.
module xnor_reduce_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
`ifdef XNOR_REDUCE_SCHED_MODE_EN
  input  logic [NREQ-1:0]          req_mode,
`endif
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_data,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     busy
);

  localparam int PASSES = WIDTH / SLICE;
  localparam int IDW    = $clog2(NREQ);
  localparam int CW     = $clog2(PASSES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_acc;
  logic [CW-1:0]    r_cnt;
  logic [IDW-1:0]   r_last;
  logic             r_res_valid;
  logic             r_res_data;
  logic [IDW-1:0]   r_res_id;
  logic             w_any;
  logic [IDW-1:0]   w_gidx;
  logic             w_acc_next;
  logic             w_last_pass;
  logic             w_invert;
  int unsigned      w_idx;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_idx  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = (32'(r_last) + k) % NREQ;
      if (!w_any && req_valid[w_idx]) begin
        w_any  = 1'b1;
        w_gidx = IDW'(w_idx);
      end
    end
  end

  assign w_acc_next  = r_acc ^ (^r_shreg[SLICE-1:0]);
  assign w_last_pass = (r_cnt == CW'(PASSES - 1));

`ifdef XNOR_REDUCE_SCHED_MODE_EN
  logic r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else if (r_state == IDLE && w_any) begin
      r_mode <= req_mode[w_gidx];
    end
  end

  assign w_invert = ~r_mode;
`else
  assign w_invert = 1'b1;
`endif

  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready[w_gidx] = 1'b1;
          w_next_state      = RUN;
        end
      end
      RUN: begin
        if (w_last_pass) w_next_state = DONE;
      end
      DONE: begin
        if (r_res_valid && res_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_acc       <= 1'b0;
      r_cnt       <= '0;
      r_last      <= IDW'(NREQ - 1);
      r_res_valid <= 1'b0;
      r_res_data  <= 1'b0;
      r_res_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_shreg  <= req_data[w_gidx*WIDTH +: WIDTH];
            r_acc    <= 1'b0;
            r_cnt    <= '0;
            r_res_id <= w_gidx;
            r_last   <= w_gidx;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_shreg <= r_shreg >> SLICE;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last_pass) begin
            r_res_data  <= w_acc_next ^ w_invert;
            r_res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = (r_state != IDLE);

endmodule
